wb_packer: RTL and testbench



---
 rtl/wb_packer_pkg.sv | 9 +
 rtl/wb_lane_pack.sv | 67 ++++++
 rtl/wb_packer.sv | 81 ++++++++
 tb/tb_wb_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_packer_pkg.sv
// Shared constants for the write-back packer: burst geometry and FSM encoding.
package wb_packer_pkg;
   localparam int DEF_BURST_LEN = 8;
   localparam int FP16_W        = 16;

   localparam logic [1:0] ST_ACCUM = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_REQ   = 2'd2;
endpackage

// File: rtl/wb_lane_pack.sv
// Lane counter, pack register and mask generation; emits one registered packed
// word per completed burst, or a zero-filled partial word on flush.
module wb_lane_pack
   import wb_packer_pkg::*;
#(
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [FP16_W-1:0]             data,
   input  logic                          flush,
   output logic [FP16_W*BURST_LEN-1:0]   word,
   output logic [BURST_LEN-1:0]          mask,
   output logic                          done
);
   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN-1);

   logic [CNT_W-1:0]                     lane_cnt;
   logic [BURST_LEN-1:0][FP16_W-1:0]     pack, pack_nxt, part_word;
   logic [BURST_LEN-1:0]                 part_mask;
   logic                                 last_lane;

   assign last_lane = en && (lane_cnt == LAST);

   always_comb begin
      pack_nxt = pack;
      if (en) pack_nxt[lane_cnt] = data;
   end

   // Lanes at or above lane_cnt hold stale data from an earlier burst.
   for (genvar g = 0; g < BURST_LEN; g++) begin : g_lane
      localparam logic [CNT_W-1:0] IDX = CNT_W'(g);
      assign part_mask[g] = IDX < lane_cnt;
      assign part_word[g] = part_mask[g] ? pack[g] : '0;
   end

   // word/mask form the output buffer, so pack refills while a write drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt <= '0;
         pack     <= '0;
         word     <= '0;
         mask     <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         pack <= pack_nxt;
         if (last_lane) begin
            lane_cnt <= '0;
            word     <= pack_nxt;
            mask     <= '1;
            done     <= 1'b1;
         end else if (flush) begin
            lane_cnt <= '0;
            if (lane_cnt != '0) begin
               word <= part_word;
               mask <= part_mask;
               done <= 1'b1;
            end
         end else if (en) begin
            lane_cnt <= lane_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_packer.sv
// Result-stream packer: collects FP16 words into bursts, writes them to the
// output RAM, flushes on gemm_finish and hands the buffer to the DMA.
module wb_packer
   import wb_packer_pkg::*;
#(
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int ADDR_W    = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          output_en,
   input  logic [FP16_W-1:0]             output_data,
   input  logic                          gemm_finish,
   output logic                          o_ram_wr_en,
   output logic [ADDR_W-1:0]             o_ram_wr_addr,
   output logic [FP16_W*BURST_LEN-1:0]   o_ram_wr_data,
   output logic [BURST_LEN-1:0]          o_ram_wr_mask,
   output logic                          wb_req,
   output logic [ADDR_W:0]               wb_words,
   input  logic                          wb_ack,
   output logic                          err_overrun
);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   logic [1:0]        state;
   logic              accept, flush, done, full, wr_fire;
   logic [ADDR_W:0]   word_cnt;
   logic [ADDR_W-1:0] wr_addr;

   assign accept = output_en && (state == ST_ACCUM);
   assign flush  = (state == ST_FLUSH);

   wb_lane_pack #(.BURST_LEN(BURST_LEN)) u_lane_pack (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .data  (output_data),
      .flush (flush),
      .word  (o_ram_wr_data),
      .mask  (o_ram_wr_mask),
      .done  (done)
   );

   assign full          = word_cnt[ADDR_W];
   assign wr_fire       = done && !full;
   assign o_ram_wr_en   = wr_fire;
   assign o_ram_wr_addr = wr_addr;

   // A flush write lands on the first REQ cycle; hold off the request until
   // it has been counted so wb_words is final when wb_req rises.
   assign wb_req   = (state == ST_REQ) && !done;
   assign wb_words = wb_req ? word_cnt : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_ACCUM;
         word_cnt    <= '0;
         wr_addr     <= '0;
         err_overrun <= 1'b0;
      end else begin
         if ((output_en && state != ST_ACCUM) || (done && full))
            err_overrun <= 1'b1;
         if (wr_fire) begin
            word_cnt <= word_cnt + 1'b1;
            if (wr_addr != ADDR_MAX) wr_addr <= wr_addr + 1'b1;
         end
         case (state)
            ST_ACCUM: if (gemm_finish) state <= ST_FLUSH;
            ST_FLUSH: state <= ST_REQ;
            ST_REQ: begin
               if (wb_req && wb_ack) begin
                  state    <= ST_ACCUM;
                  word_cnt <= '0;
                  wr_addr  <= '0;
               end
            end
            default: state <= ST_ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_packer.sv
// Directed bench for wb_packer: full bursts, flush, handoff, overrun, reset.
module tb_wb_packer;
   localparam int BL  = 8;
   localparam int AW  = 10;
   localparam int AWS = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic          output_en = 1'b0, gemm_finish = 1'b0, wb_ack = 1'b0;
   logic [15:0]   output_data = '0;
   logic          o_ram_wr_en, wb_req, err_overrun;
   logic [AW-1:0] o_ram_wr_addr;
   logic [127:0]  o_ram_wr_data;
   logic [BL-1:0] o_ram_wr_mask;
   logic [AW:0]   wb_words;

   logic           s_en = 1'b0, s_fin = 1'b0, s_ack = 1'b0;
   logic [15:0]    s_data = '0;
   logic           s_wr_en, s_req, s_err;
   logic [AWS-1:0] s_addr;
   logic [127:0]   s_wdata;
   logic [BL-1:0]  s_mask;
   logic [AWS:0]   s_words;

   int assertions = 0;
   int failures   = 0;

   int            wcnt = 0;
   logic [AW-1:0] la [16];
   logic [127:0]  ld [16];
   logic [BL-1:0] lm [16];
   int             swcnt = 0;
   logic [AWS-1:0] sla [16];

   always #5 clk = ~clk;

   wb_packer #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .output_en(output_en), .output_data(output_data),
      .gemm_finish(gemm_finish), .o_ram_wr_en(o_ram_wr_en), .o_ram_wr_addr(o_ram_wr_addr),
      .o_ram_wr_data(o_ram_wr_data), .o_ram_wr_mask(o_ram_wr_mask), .wb_req(wb_req),
      .wb_words(wb_words), .wb_ack(wb_ack), .err_overrun(err_overrun));

   wb_packer #(.BURST_LEN(BL), .ADDR_W(AWS)) dut_s (
      .clk(clk), .rst_n(rst_n), .output_en(s_en), .output_data(s_data),
      .gemm_finish(s_fin), .o_ram_wr_en(s_wr_en), .o_ram_wr_addr(s_addr),
      .o_ram_wr_data(s_wdata), .o_ram_wr_mask(s_mask), .wb_req(s_req),
      .wb_words(s_words), .wb_ack(s_ack), .err_overrun(s_err));

   always @(negedge clk) begin
      if (o_ram_wr_en === 1'b1) begin
         if (wcnt < 16) begin
            la[wcnt] = o_ram_wr_addr;
            ld[wcnt] = o_ram_wr_data;
            lm[wcnt] = o_ram_wr_mask;
         end
         wcnt++;
      end
      if (s_wr_en === 1'b1) begin
         if (swcnt < 16) sla[swcnt] = s_addr;
         swcnt++;
      end
   end

   task automatic drive(input logic en, input logic [15:0] d, input logic fin);
      @(negedge clk);
      output_en = en; output_data = d; gemm_finish = fin;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 16'h0, 1'b0);
   endtask

   task automatic drive_s(input logic en, input logic [15:0] d, input logic fin);
      @(negedge clk);
      s_en = en; s_data = d; s_fin = fin;
   endtask

   task automatic wait_req(input string name);
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         idle(1);
         if (wb_req === 1'b1) ok = 1;
      end
      assertions++;
      if (!ok) begin failures++; $display("FAIL %s_req: wb_req never rose within 20 cycles", name); end
   endtask

   task automatic do_ack(input string name);
      @(negedge clk); wb_ack = 1'b1;
      @(negedge clk); wb_ack = 1'b0;
      assertions++;
      if (wb_req !== 1'b0) begin failures++; $display("FAIL %s_ack: wb_req=%0b want 0", name, wb_req); end
   endtask

   task automatic test_reset;
      idle(2);
      assertions++;
      if ({o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_wr_mask, wb_req, wb_words, err_overrun} !== '0) begin
         failures++; $display("FAIL reset_outputs: some output nonzero (wr_en=%0b req=%0b err=%0b)", o_ram_wr_en, wb_req, err_overrun);
      end
      @(negedge clk); rst_n = 1'b1;
      idle(2);
      assertions++;
      if ({o_ram_wr_en, wb_req, wb_words, err_overrun} !== '0) begin
         failures++; $display("FAIL reset_release: wr_en=%0b req=%0b words=%0d err=%0b want 0", o_ram_wr_en, wb_req, wb_words, err_overrun);
      end
   endtask

   task automatic test_single;
      for (int n = 1; n <= 8; n++) drive(1'b1, 16'(n), 1'b0);
      idle(1);
      assertions++;
      if (o_ram_wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en: got %0b want 1", o_ram_wr_en); end
      assertions++;
      if (o_ram_wr_addr !== 10'd0 || o_ram_wr_mask !== 8'hFF) begin
         failures++; $display("FAIL single_addr_mask: addr=%0d mask=%h want 0/ff", o_ram_wr_addr, o_ram_wr_mask);
      end
      assertions++;
      if (o_ram_wr_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
         failures++; $display("FAIL single_data: got %h want 00080007000600050004000300020001", o_ram_wr_data);
      end
      idle(1);
      assertions++;
      if (o_ram_wr_en !== 1'b0) begin failures++; $display("FAIL single_one_write: wr_en=%0b want 0", o_ram_wr_en); end
      drive(1'b0, 16'h0, 1'b1);
      wait_req("single");
      assertions++;
      if (wb_words !== 11'd1) begin failures++; $display("FAIL single_words: got %0d want 1", wb_words); end
      do_ack("single");
   endtask

   task automatic test_partial;
      wcnt = 0;
      for (int n = 0; n < 20; n++) drive(1'b1, 16'(16'h0100 + n), 1'b0);
      drive(1'b0, 16'h0, 1'b1);
      wait_req("partial");
      assertions++;
      if (wcnt !== 3) begin failures++; $display("FAIL partial_count: got %0d writes want 3", wcnt); end
      assertions++;
      if (la[0] !== 10'd0 || lm[0] !== 8'hFF || ld[0][15:0] !== 16'h0100 || ld[0][127:112] !== 16'h0107) begin
         failures++; $display("FAIL partial_w0: addr=%0d mask=%h data=%h want 0/ff/0107..0100", la[0], lm[0], ld[0]);
      end
      assertions++;
      if (la[1] !== 10'd1 || lm[1] !== 8'hFF || ld[1][15:0] !== 16'h0108) begin
         failures++; $display("FAIL partial_w1: addr=%0d mask=%h lane0=%h want 1/ff/0108", la[1], lm[1], ld[1][15:0]);
      end
      assertions++;
      if (la[2] !== 10'd2 || lm[2] !== 8'h0F || ld[2] !== 128'h0000_0000_0000_0000_0113_0112_0111_0110) begin
         failures++; $display("FAIL partial_w2: addr=%0d mask=%h data=%h want 2/0f/zero-filled 0113..0110", la[2], lm[2], ld[2]);
      end
      assertions++;
      if (wb_words !== 11'd3) begin failures++; $display("FAIL partial_words: got %0d want 3", wb_words); end
      idle(3);
      assertions++;
      if (wb_req !== 1'b1 || wb_words !== 11'd3) begin
         failures++; $display("FAIL partial_hold: req=%0b words=%0d want 1/3", wb_req, wb_words);
      end
      do_ack("partial");
   endtask

   task automatic test_finish_same;
      wcnt = 0;
      for (int n = 0; n < 7; n++) drive(1'b1, 16'(16'h0200 + n), 1'b0);
      drive(1'b1, 16'h0207, 1'b1);
      wait_req("same");
      assertions++;
      if (wcnt !== 1 || lm[0] !== 8'hFF || ld[0][127:112] !== 16'h0207) begin
         failures++; $display("FAIL same_write: count=%0d mask=%h lane7=%h want 1/ff/0207", wcnt, lm[0], ld[0][127:112]);
      end
      assertions++;
      if (wb_words !== 11'd1) begin failures++; $display("FAIL same_words: got %0d want 1", wb_words); end
      do_ack("same");
   endtask

   task automatic test_overrun;
      assertions++;
      if (err_overrun !== 1'b0) begin failures++; $display("FAIL ovr_pre: err=%0b want 0", err_overrun); end
      drive(1'b0, 16'h0, 1'b1);
      wait_req("empty");
      assertions++;
      if (wb_words !== 11'd0) begin failures++; $display("FAIL empty_words: got %0d want 0", wb_words); end
      wcnt = 0;
      for (int n = 0; n < 8; n++) drive(1'b1, 16'(16'h0300 + n), 1'b0);
      idle(2);
      assertions++;
      if (wcnt !== 0 || err_overrun !== 1'b1 || wb_req !== 1'b1) begin
         failures++; $display("FAIL ovr_drop: writes=%0d err=%0b req=%0b want 0/1/1", wcnt, err_overrun, wb_req);
      end
      do_ack("ovr");
      wcnt = 0;
      for (int n = 0; n < 8; n++) drive(1'b1, 16'(16'h0400 + n), 1'b0);
      idle(2);
      assertions++;
      if (wcnt !== 1 || la[0] !== 10'd0 || ld[0][15:0] !== 16'h0400 || err_overrun !== 1'b1) begin
         failures++; $display("FAIL ovr_after_ack: writes=%0d addr=%0d lane0=%h err=%0b want 1/0/0400/1", wcnt, la[0], ld[0][15:0], err_overrun);
      end
      drive(1'b0, 16'h0, 1'b1);
      wait_req("ovr2");
      do_ack("ovr2");
   endtask

   task automatic test_small_ram;
      bit ok = 0;
      swcnt = 0;
      for (int n = 0; n < 32; n++) drive_s(1'b1, 16'(n), 1'b0);
      drive_s(1'b0, 16'h0, 1'b0);
      idle(2);
      assertions++;
      if (swcnt !== 4 || s_err !== 1'b0) begin
         failures++; $display("FAIL small_fill: writes=%0d err=%0b want 4/0", swcnt, s_err);
      end
      for (int n = 32; n < 40; n++) drive_s(1'b1, 16'(n), 1'b0);
      drive_s(1'b0, 16'h0, 1'b0);
      idle(2);
      assertions++;
      if (swcnt !== 4 || s_err !== 1'b1) begin
         failures++; $display("FAIL small_full: writes=%0d err=%0b want 4/1", swcnt, s_err);
      end
      for (int i = 0; i < 4; i++) begin
         assertions++;
         if (sla[i] !== 2'(i)) begin failures++; $display("FAIL small_addr%0d: got %0d want %0d", i, sla[i], i); end
      end
      drive_s(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 20 && !ok; i++) begin
         drive_s(1'b0, 16'h0, 1'b0);
         if (s_req === 1'b1) ok = 1;
      end
      assertions++;
      if (!ok || s_words !== 3'd4) begin
         failures++; $display("FAIL small_words: req=%0b words=%0d want 1/4", s_req, s_words);
      end
      @(negedge clk); s_ack = 1'b1;
      @(negedge clk); s_ack = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [127:0] exp_w;
      for (int n = 0; n < 3; n++) drive(1'b1, 16'(16'h0500 + n), 1'b0);
      @(negedge clk); output_en = 1'b0; rst_n = 1'b0;
      #1;
      assertions++;
      if ({o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_wr_mask, wb_req, wb_words, err_overrun} !== '0) begin
         failures++; $display("FAIL rstmid_outputs: wr_en=%0b req=%0b err=%0b want all 0", o_ram_wr_en, wb_req, err_overrun);
      end
      idle(2);
      @(negedge clk); rst_n = 1'b1;
      wcnt = 0;
      idle(3);
      assertions++;
      if (wcnt !== 0) begin failures++; $display("FAIL rstmid_no_write: writes=%0d want 0", wcnt); end
      exp_w = '0;
      for (int n = 0; n < 8; n++) begin
         exp_w[n*16 +: 16] = 16'(16'hC000 + n);
         drive(1'b1, 16'(16'hC000 + n), 1'b0);
      end
      idle(1);
      assertions++;
      if (o_ram_wr_en !== 1'b1 || o_ram_wr_addr !== 10'd0 || o_ram_wr_data !== exp_w) begin
         failures++; $display("FAIL rstmid_new_word: en=%0b addr=%0d data=%h want 1/0/%h", o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, exp_w);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_partial();
      test_finish_same();
      test_overrun();
      test_small_ram();
      test_reset_mid();
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
